// File: rtl/sysid_ctrl_pkg.sv
// Shared types and constants for the system-ID boot check sequencer.
// Contents: FSM state encoding, sysid word addresses, latency counter width.
package sysid_ctrl_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ID   = 3'd1,
    ST_WAIT_ID = 3'd2,
    ST_RD_TS   = 3'd3,
    ST_WAIT_TS = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // Sysid slave word select
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Read latency counter width (latency 0..7)
  localparam int unsigned LAT_CNT_W = 3;

endpackage

// File: rtl/sysid_check_ctrl.sv
// Boot-time sequencer for the system-ID Avalon slave: reads the ID word and
// build timestamp, compares them against expected constants, retries on a
// mismatch and reports pass/error.
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   start               one-cycle start request (ignored while busy)
//   avm_address/read    Avalon master word select and read strobe
//   avm_readdata        sysid read data
//   sysid_id/timestamp  last captured words
//   busy, done          sequence in progress / finished (level)
//   id_ok, ts_ok, error compare results, valid while done=1
//   retry_cnt           retries consumed in the current or last sequence
module sysid_check_ctrl
  import sysid_ctrl_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'd1512962896,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_RETRY    = 3,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic [31:0] sysid_id,
  output logic [31:0] sysid_timestamp,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        error,
  output logic [3:0]  retry_cnt
);

  localparam int unsigned LAT_LAST = (READ_LATENCY == 0) ? 0 : READ_LATENCY - 1;
  localparam logic [LAT_CNT_W-1:0] LAT_LAST_C  = LAT_CNT_W'(LAT_LAST);
  localparam logic [3:0]           MAX_RETRY_C = 4'(MAX_RETRY);

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_pending;
  logic [LAT_CNT_W-1:0] r_lat_cnt;
  logic                 r_avm_address;
  logic                 r_avm_read;
  logic [31:0]          r_sysid_id;
  logic [31:0]          r_sysid_timestamp;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_id_ok;
  logic                 r_ts_ok;
  logic                 r_error;
  logic [3:0]           r_retry_cnt;

  logic                 w_launch;
  logic                 w_lat_last;
  logic                 w_id_match;
  logic                 w_ts_match;
  logic                 w_can_retry;
  logic [LAT_CNT_W-1:0] w_lat_nxt;
  logic                 w_addr_nxt;
  logic                 w_read_nxt;
  logic [31:0]          w_id_nxt;
  logic [31:0]          w_ts_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic                 w_id_ok_nxt;
  logic                 w_ts_ok_nxt;
  logic                 w_error_nxt;
  logic [3:0]           w_retry_nxt;

  assign w_launch    = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && (start || r_pending);
  assign w_lat_last  = (r_lat_cnt == LAT_LAST_C);
  assign w_id_match  = (r_sysid_id == EXPECTED_ID);
  assign w_ts_match  = (r_sysid_timestamp == EXPECTED_TS);
  assign w_can_retry = (r_retry_cnt < MAX_RETRY_C);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_launch) w_state_nxt = ST_RD_ID;
      // At zero latency the wait states are skipped; data is valid with the strobe
      ST_RD_ID:   w_state_nxt = (READ_LATENCY == 0) ? ST_RD_TS : ST_WAIT_ID;
      ST_WAIT_ID: if (w_lat_last) w_state_nxt = ST_RD_TS;
      ST_RD_TS:   w_state_nxt = (READ_LATENCY == 0) ? ST_CHECK : ST_WAIT_TS;
      ST_WAIT_TS: if (w_lat_last) w_state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (w_id_match && w_ts_match) w_state_nxt = ST_DONE;
        else if (w_can_retry)         w_state_nxt = ST_RD_ID;
        else                          w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs and datapath
  always_comb begin
    w_read_nxt  = 1'b0;
    w_addr_nxt  = r_avm_address;
    w_id_nxt    = r_sysid_id;
    w_ts_nxt    = r_sysid_timestamp;
    w_lat_nxt   = '0;
    w_done_nxt  = r_done;
    w_id_ok_nxt = r_id_ok;
    w_ts_ok_nxt = r_ts_ok;
    w_error_nxt = r_error;
    w_retry_nxt = r_retry_cnt;
    w_busy_nxt  = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);

    if (w_launch) begin
      w_done_nxt  = 1'b0;
      w_id_ok_nxt = 1'b0;
      w_ts_ok_nxt = 1'b0;
      w_error_nxt = 1'b0;
      w_retry_nxt = 4'd0;
    end

    // Strobe is raised on the edge entering a read state, so it lasts exactly that state
    if (w_state_nxt == ST_RD_ID) begin
      w_read_nxt = 1'b1;
      w_addr_nxt = SYSID_ADDR_ID;
    end else if (w_state_nxt == ST_RD_TS) begin
      w_read_nxt = 1'b1;
      w_addr_nxt = SYSID_ADDR_TS;
    end

    case (r_state)
      ST_RD_ID: if (READ_LATENCY == 0) w_id_nxt = avm_readdata;
      ST_RD_TS: if (READ_LATENCY == 0) w_ts_nxt = avm_readdata;
      ST_WAIT_ID: begin
        if (w_lat_last) w_id_nxt  = avm_readdata;
        else            w_lat_nxt = LAT_CNT_W'(r_lat_cnt + 1'b1);
      end
      ST_WAIT_TS: begin
        if (w_lat_last) w_ts_nxt  = avm_readdata;
        else            w_lat_nxt = LAT_CNT_W'(r_lat_cnt + 1'b1);
      end
      ST_CHECK: begin
        if (w_id_match && w_ts_match) begin
          w_done_nxt  = 1'b1;
          w_id_ok_nxt = 1'b1;
          w_ts_ok_nxt = 1'b1;
          w_error_nxt = 1'b0;
        end else if (w_can_retry) begin
          w_retry_nxt = 4'(r_retry_cnt + 4'd1);
        end else begin
          w_done_nxt  = 1'b1;
          w_id_ok_nxt = w_id_match;
          w_ts_ok_nxt = w_ts_match;
          w_error_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath; pending start re-arms on every reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending         <= AUTO_START;
      r_lat_cnt         <= '0;
      r_avm_address     <= SYSID_ADDR_ID;
      r_avm_read        <= 1'b0;
      r_sysid_id        <= '0;
      r_sysid_timestamp <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_id_ok           <= 1'b0;
      r_ts_ok           <= 1'b0;
      r_error           <= 1'b0;
      r_retry_cnt       <= 4'd0;
    end else begin
      r_pending         <= 1'b0;
      r_lat_cnt         <= w_lat_nxt;
      r_avm_address     <= w_addr_nxt;
      r_avm_read        <= w_read_nxt;
      r_sysid_id        <= w_id_nxt;
      r_sysid_timestamp <= w_ts_nxt;
      r_busy            <= w_busy_nxt;
      r_done            <= w_done_nxt;
      r_id_ok           <= w_id_ok_nxt;
      r_ts_ok           <= w_ts_ok_nxt;
      r_error           <= w_error_nxt;
      r_retry_cnt       <= w_retry_nxt;
    end
  end

  assign avm_address     = r_avm_address;
  assign avm_read        = r_avm_read;
  assign sysid_id        = r_sysid_id;
  assign sysid_timestamp = r_sysid_timestamp;
  assign busy            = r_busy;
  assign done            = r_done;
  assign id_ok           = r_id_ok;
  assign ts_ok           = r_ts_ok;
  assign error           = r_error;
  assign retry_cnt       = r_retry_cnt;

endmodule
